// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART transmitter, LSB first, with a one-byte holding register so the next
// byte can be handed over while the current frame shifts out (no idle gap between frames).
//
// Ports:
//   clk_i              system clock
//   rst_i              asynchronous, active-high reset
//   tx_byte_i          byte to send, sampled on the accept edge
//   tx_valid_i         producer has a byte
//   tx_ready_o         holding register empty; transfer on tx_valid_i & tx_ready_o
//   tx_o               serial line, idle high
//   is_transmitting_o  high while a start, data or stop bit is on the line
//   tx_done_o          one-cycle pulse in the last cycle of each stop bit
module uart_byte_tx #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       is_transmitting_o,
    output logic       tx_done_o
);

    localparam logic [15:0] BaudLoad = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_zero;

    assign baud_zero = (baud_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;

        if (state_q != StIdle && !baud_zero) begin
            baud_d = baud_q - 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = StStart;
                    tx_d        = 1'b0;
                    baud_d      = BaudLoad;
                end
            end
            StStart: begin
                if (baud_zero) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    baud_d    = BaudLoad;
                end
            end
            StData: begin
                if (baud_zero) begin
                    baud_d = BaudLoad;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (baud_zero) begin
                    if (hold_full_q) begin
                        // Pending byte: start bit follows the stop bit with no idle cycle.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = StStart;
                        tx_d        = 1'b0;
                        baud_d      = BaudLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept only into an empty holding register; the loads above only fire when it is full,
        // so the two never collide.
        if (tx_valid_i && !hold_full_q) begin
            hold_d      = tx_byte_i;
            hold_full_d = 1'b1;
        end
    end

    assign busy_d = (state_d != StIdle);
    assign done_d = (state_d == StStop) && (baud_d == 16'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            baud_q      <= 16'd0;
            bit_idx_q   <= 3'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready_o        = ~hold_full_q;
    assign tx_o              = tx_q;
    assign is_transmitting_o = busy_q;
    assign tx_done_o         = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed checks of uart_byte_tx with CLK_DIV=4, plus a second instance at
// CLK_DIV=65535 for the start-bit width at the maximum divisor.
module tb_uart_byte_tx;

    localparam int unsigned Div    = 4;
    localparam int unsigned MaxDiv = 65535;
    localparam int          NS     = 256;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] tx_byte_i = 8'd0;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o, tx_o, is_transmitting_o, tx_done_o;

    logic [7:0] m_byte = 8'd0;
    logic       m_valid = 1'b0;
    logic       m_ready, m_tx, m_busy, m_done;

    always #5 clk_i = ~clk_i;

    uart_byte_tx #(.CLK_DIV(Div)) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tx_byte_i        (tx_byte_i),
        .tx_valid_i       (tx_valid_i),
        .tx_ready_o       (tx_ready_o),
        .tx_o             (tx_o),
        .is_transmitting_o(is_transmitting_o),
        .tx_done_o        (tx_done_o)
    );

    uart_byte_tx #(.CLK_DIV(MaxDiv)) u_dut_max (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tx_byte_i        (m_byte),
        .tx_valid_i       (m_valid),
        .tx_ready_o       (m_ready),
        .tx_o             (m_tx),
        .is_transmitting_o(m_busy),
        .tx_done_o        (m_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Samples taken #1 after edge c, and the expected line/flags for the same slot.
    logic s_tx[NS], s_busy[NS], s_done[NS], s_ready[NS];
    logic e_tx[NS], e_busy[NS], e_done[NS];
    logic [7:0] q_byte[8];
    int q_at[8];
    int q_n, q_head, n_acc;
    int acc_cyc[8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        tx_valid_i = 1'b0;
        m_valid    = 1'b0;
        rst_i      = 1'b1;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_run();
        for (int i = 0; i < NS; i++) begin
            e_tx[i]   = 1'b1;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
        end
        q_n    = 0;
        q_head = 0;
        n_acc  = 0;
        for (int i = 0; i < 8; i++) acc_cyc[i] = -1;
    endtask

    task automatic offer(input logic [7:0] b, input int at);
        q_byte[q_n] = b;
        q_at[q_n]   = at;
        q_n++;
    endtask

    // Expected frame whose start bit is first sampled in slot 'start'.
    task automatic add_frame(input int start, input logic [7:0] b);
        int bit_n;
        for (int k = 0; k < 10 * Div; k++) begin
            bit_n = k / Div;
            if (bit_n == 0) e_tx[start + k] = 1'b0;
            else if (bit_n == 9) e_tx[start + k] = 1'b1;
            else e_tx[start + k] = b[bit_n - 1];
            e_busy[start + k] = 1'b1;
        end
        e_done[start + 10 * Div - 1] = 1'b1;
    endtask

    task automatic run(input int n);
        logic acc;
        for (int c = 0; c < n; c++) begin
            if (q_head < q_n && c >= q_at[q_head]) begin
                tx_valid_i = 1'b1;
                tx_byte_i  = q_byte[q_head];
            end else begin
                tx_valid_i = 1'b0;
                tx_byte_i  = 8'($urandom);
            end
            acc = tx_valid_i & tx_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) begin
                if (n_acc < 8) acc_cyc[n_acc] = c;
                n_acc++;
                q_head++;
            end
            s_tx[c]    = tx_o;
            s_busy[c]  = is_transmitting_o;
            s_done[c]  = tx_done_o;
            s_ready[c] = tx_ready_o;
        end
        tx_valid_i = 1'b0;
    endtask

    task automatic compare_run(input string tag, input int n);
        int etx, ebusy, edone;
        etx = 0; ebusy = 0; edone = 0;
        for (int c = 0; c < n; c++) begin
            if (s_tx[c] !== e_tx[c]) etx++;
            if (s_busy[c] !== e_busy[c]) ebusy++;
            if (s_done[c] !== e_done[c]) edone++;
        end
        check_eq({tag, "_tx_errs"}, etx, 0);
        check_eq({tag, "_busy_errs"}, ebusy, 0);
        check_eq({tag, "_done_errs"}, edone, 0);
    endtask

    initial begin
        int lowcnt;
        int w;

        // Reset values, checked while reset is held.
        #12;
        check_eq("rst_tx", tx_o, 1);
        check_eq("rst_busy", is_transmitting_o, 0);
        check_eq("rst_done", tx_done_o, 0);
        check_eq("rst_ready", tx_ready_o, 1);
        check_eq("rst_max_tx", m_tx, 1);
        do_reset();

        // Single byte 0xA5.
        clear_run();
        offer(8'hA5, 0);
        add_frame(1, 8'hA5);
        run(45);
        compare_run("single", 45);
        check_eq("single_acc_n", n_acc, 1);
        check_eq("single_ready_after_accept", s_ready[0], 0);
        check_eq("single_ready_after_load", s_ready[1], 1);

        // Back-to-back word 0x12, 0x34.
        do_reset();
        clear_run();
        offer(8'h12, 0);
        offer(8'h34, 0);
        add_frame(1, 8'h12);
        add_frame(41, 8'h34);
        run(85);
        compare_run("b2b", 85);
        check_eq("b2b_acc_n", n_acc, 2);
        check_eq("b2b_second_accept_edge", acc_cyc[1], 2);

        // Backpressure: three bytes offered continuously.
        do_reset();
        clear_run();
        offer(8'h01, 0);
        offer(8'h02, 0);
        offer(8'h03, 0);
        add_frame(1, 8'h01);
        add_frame(41, 8'h02);
        add_frame(81, 8'h03);
        run(125);
        compare_run("bp", 125);
        check_eq("bp_acc_n", n_acc, 3);
        check_eq("bp_third_accept_edge", acc_cyc[2], 42);
        lowcnt = 0;
        for (int c = 0; c < 125; c++) if (s_ready[c] === 1'b0) lowcnt++;
        check_eq("bp_ready_low_cycles", lowcnt, 79);

        // Late offer exactly at the last stop-bit edge: one idle cycle, then start.
        do_reset();
        clear_run();
        offer(8'h3C, 0);
        offer(8'hFF, 41);
        add_frame(1, 8'h3C);
        add_frame(42, 8'hFF);
        run(90);
        compare_run("late", 90);
        check_eq("late_accept_edge", acc_cyc[1], 41);

        // Reset during data bit 3 of 0x0F with 0xF0 pending.
        do_reset();
        clear_run();
        offer(8'h0F, 0);
        offer(8'hF0, 0);
        run(18);
        check_eq("mid_pending_ready", s_ready[17], 0);
        check_eq("mid_busy_before", s_busy[17], 1);
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_tx", tx_o, 1);
        check_eq("mid_rst_busy", is_transmitting_o, 0);
        check_eq("mid_rst_ready", tx_ready_o, 1);
        check_eq("mid_rst_done", tx_done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        clear_run();
        run(60);
        compare_run("post_rst_idle", 60);
        clear_run();
        offer(8'h5A, 0);
        add_frame(1, 8'h5A);
        run(45);
        compare_run("post_rst_new", 45);

        // Maximum divisor: start bit width, with data bit 0 high to mark its end.
        do_reset();
        m_valid = 1'b1;
        m_byte  = 8'h01;
        @(posedge clk_i);
        #1;
        m_valid = 1'b0;
        m_byte  = 8'hFE;
        check_eq("max_ready_after_accept", m_ready, 0);
        w = 0;
        while (m_tx !== 1'b0 && w < 4) begin
            @(posedge clk_i);
            #1;
            w++;
        end
        check_eq("max_start_seen", m_tx, 0);
        lowcnt = 0;
        while (m_tx === 1'b0 && lowcnt < 70000) begin
            lowcnt++;
            @(posedge clk_i);
            #1;
        end
        check_eq("max_start_width", lowcnt, MaxDiv);
        check_eq("max_bit0", m_tx, 1);
        check_eq("max_busy", m_busy, 1);
        check_eq("max_done", m_done, 0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
